// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake and result flags.
// Optional signed saturation is compiled in when ADDSUB_SATURATE_EN is defined.
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NREG = (STAGES > 1) ? STAGES - 1 : 1;

    // Everything a beat needs on its way down the carry chain.
    typedef struct packed {
        logic             v;
        logic             sat;
        logic             c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] bc;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t           mid_q [NREG];
    stage_t           stg   [STAGES];
    stage_t           nx    [STAGES];
    logic [SEG:0]     seg_sum;
    logic             adv;

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q, zero_q, neg_q;
    logic [WIDTH-1:0] raw_d, s_d;
    logic             cout_d, ovf_d, zero_d, neg_d;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stg[k] = '0;
        end
        stg[0].v  = in_valid;
        stg[0].a  = a;
        stg[0].bc = b ^ {WIDTH{sub}};
        stg[0].c  = sub;
        stg[0].s  = '0;
`ifdef ADDSUB_SATURATE_EN
        stg[0].sat = sat;
`else
        stg[0].sat = 1'b0;
`endif
        for (int k = 1; k < STAGES; k++) begin
            stg[k] = mid_q[k-1];
        end
    end

    // Stage k resolves bits [k*SEG +: SEG] using the carry left by stage k-1.
    always_comb begin
        seg_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            nx[k]   = stg[k];
            seg_sum = {1'b0, stg[k].a[k*SEG +: SEG]}
                    + {1'b0, stg[k].bc[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, stg[k].c};
            nx[k].s[k*SEG +: SEG] = seg_sum[SEG-1:0];
            nx[k].c               = seg_sum[SEG];
        end
    end

    always_comb begin
        raw_d  = nx[STAGES-1].s;
        cout_d = nx[STAGES-1].c;
        ovf_d  = (nx[STAGES-1].a[WIDTH-1] == nx[STAGES-1].bc[WIDTH-1])
              && (raw_d[WIDTH-1] != nx[STAGES-1].a[WIDTH-1]);
        s_d    = raw_d;
`ifdef ADDSUB_SATURATE_EN
        if (nx[STAGES-1].sat && ovf_d) begin
            s_d = nx[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (s_d == '0);
        neg_d  = s_d[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                mid_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                mid_q[k] <= nx[k];
            end
            out_valid_q <= nx[STAGES-1].v;
            s_q         <= s_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe (WIDTH=16, STAGES=4): directed vector table plus
// stall, bubble and reset sequences against an independent 17-bit arithmetic model.
module tb_addsub_pipe;

    localparam int W  = 16;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, sub, sat, out_valid, out_ready;
    logic [W-1:0]  a, b, s;
    logic          cout, ovf, zero, neg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub, sat;
        logic [W-1:0] s;
        logic         cout, ovf, zero, neg;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         cout, ovf, zero, neg;
    } res_t;

    vec_t vecs [13];

    addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic msat);
        logic [W:0]   sum;
        logic [W-1:0] bc;
        res_t         r;
        bc     = msub ? ~mb : mb;
        sum    = {1'b0, ma} + {1'b0, bc} + {{W{1'b0}}, msub};
        r.s    = sum[W-1:0];
        r.cout = sum[W];
        r.ovf  = (ma[W-1] == bc[W-1]) && (sum[W-1] != ma[W-1]);
`ifdef ADDSUB_SATURATE_EN
        if (msat && r.ovf) r.s = ma[W-1] ? 16'h8000 : 16'h7FFF;
`else
        if (msat) r.s = r.s;
`endif
        r.zero = (r.s == '0);
        r.neg  = r.s[W-1];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        tick();
        in_valid = 1'b1; a = v.a; b = v.b; sub = v.sub; sat = v.sat;
        #1;
        chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk($sformatf("vec%0d_not_early", idx), out_valid, 0);
        tick();
        chk($sformatf("vec%0d_out_valid", idx), out_valid, 1);
        chk($sformatf("vec%0d_s", idx), s, v.s);
        chk($sformatf("vec%0d_cout", idx), cout, v.cout);
        chk($sformatf("vec%0d_ovf", idx), ovf, v.ovf);
        chk($sformatf("vec%0d_zero", idx), zero, v.zero);
        chk($sformatf("vec%0d_neg", idx), neg, v.neg);
    endtask

    task automatic run_stream(input int n, input bit bubbles, input int st_lo,
                              input int st_hi, input string tag);
        res_t         exp_q [$];
        int           acc_q [$];
        res_t         e;
        int           sent = 0, got = 0, cyc = 0, acy;
        logic [W-1:0] ra, rb, prev_s;
        logic         rsub, rsat, prev_stall;
        prev_stall = 1'b0;
        prev_s     = '0;
        ra = W'($urandom); rb = W'($urandom);
        rsub = 1'($urandom); rsat = 1'($urandom);
        while (got < n && cyc < 200) begin
            tick();
            out_ready = !(cyc >= st_lo && cyc < st_hi);
            in_valid  = (sent < n) && (!bubbles || (cyc % 2 == 0));
            a = ra; b = rb; sub = rsub; sat = rsat;
            #1;
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_s"}, s, prev_s);
            end
            chk({tag, "_in_ready"}, in_ready, !out_valid || out_ready);
            if (!out_ready) chk({tag, "_stall_in_ready"}, in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_spurious_out"}, 1, 0);
                end else begin
                    e   = exp_q.pop_front();
                    acy = acc_q.pop_front();
                    chk($sformatf("%s_s%0d", tag, got), s, e.s);
                    chk($sformatf("%s_flags%0d", tag, got), {cout, ovf, zero, neg},
                        {e.cout, e.ovf, e.zero, e.neg});
                    if (bubbles) chk($sformatf("%s_lat%0d", tag, got), cyc - acy, ST);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(ra, rb, rsub, rsat));
                acc_q.push_back(cyc);
                sent++;
                ra = W'($urandom); rb = W'($urandom);
                rsub = 1'($urandom); rsat = 1'($urandom);
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = s;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SATURATE_EN
        vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        vecs[11] = '{16'h1000, 16'h2000, 1'b0, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {s, cout, ovf, zero, neg}, '0);
        #11 rst_n = 1'b1;

        for (int i = 0; i < 13; i++) apply_vec(i);

        run_stream(8, 1'b0, 5, 8, "stall");
        run_stream(8, 1'b1, -1, -1, "bubble");

        // Fill the stalled pipeline, then reset while the first result is presented.
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); sub = 1'b0; sat = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_ready", in_ready, 1);
        chk("rst_async_outputs", {s, cout, ovf, zero, neg}, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_ghost", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface and result flags. It generalises the team's 4-bit ripple add/sub cell in three ways: the operand width is a parameter, the carry chain is split into registered segments so wide words close timing, and each result carries status flags. It sits between the operand-fetch stream and the result writeback stream in the datapath.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be an integer multiple of `STAGES`.
- `STAGES`, 4, number of pipeline stages; each stage resolves `WIDTH/STAGES` bits of the carry chain. Legal range is 1..`WIDTH`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts the beat this cycle.
- `a`  in  `WIDTH`  operand A.
- `b`  in  `WIDTH`  operand B.
- `sub`  in  1  0: A+B; 1: A−B, computed as A + ~B + 1.
- `sat`  in  1  per-beat signed-saturation request; honoured only when `ADDSUB_SATURATE_EN` is defined.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  downstream accepts the result.
- `s`  out  `WIDTH`  result.
- `cout`  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf`  out  1  signed overflow.
- `zero`  out  1  `s` == 0.
- `neg`  out  1  `s[WIDTH-1]`.

## Operation
- Operand B is XORed with `sub` per bit, and the carry-in of segment 0 is `sub`.
- Stage k adds segment k of A and of the conditioned B, using the registered carry from stage k−1. The not-yet-consumed upper segments of A and conditioned B, the low result segments already computed, `a[WIDTH-1]`, conditioned `b[WIDTH-1]` and `sat` are carried forward with the data.
- Final stage:
  - `cout` = carry out of the MSB.
  - `ovf` = (A msb == conditioned B msb) && (raw result msb ≠ A msb).
  - `zero` and `neg` are computed on the value actually presented on `s`.
- Pipeline control is a global enable: `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv` is 1, every stage shifts one position and a valid bit travels with each stage.
  - When `adv` is 0, all stages hold.
- A beat is accepted when `in_valid && in_ready`. Bubbles propagate as invalid stages.
- `out_valid`, `s` and the flags are driven directly from the final stage registers. They hold stable while `out_valid && !out_ready`.
- Results leave in acceptance order. No beat is dropped or duplicated.
- Arithmetic is modulo 2^`WIDTH`. There is no internal width growth beyond `cout`.

## Timing
- Reset (`rst_n` low, asynchronous):
  - All valid bits clear, so `out_valid` = 0 and `in_ready` = 1.
  - `s`, `cout`, `ovf`, `zero` and `neg` go to 0.
  - Beats in flight are discarded and none emerge after reset release.
- Latency: a beat accepted at edge n with no stall shows `out_valid` = 1 after edge n+`STAGES`.
- Throughput: one beat per cycle while `out_ready` = 1.
- Stall: if `out_valid` = 1 and `out_ready` = 0, `in_ready` = 0 in the same cycle. This is a combinational path from `out_ready` to `in_ready`.
- Simultaneous output pop and input accept in one cycle is legal and required for full throughput.
- With `STAGES` = 1 the block is a single registered adder with latency 1.

## Configuration
- `ADDSUB_SATURATE_EN` defined: in the final stage, if `sat` && `ovf`, then `s` = 0 followed by all ones (signed max) when the A msb is 0, and `s` = 1 followed by all zeros (signed min) otherwise. `ovf` still reports 1, `cout` is unchanged, and `zero`/`neg` reflect the clamped value.
- `ADDSUB_SATURATE_EN` not defined: the `sat` input is ignored (no logic connected to it) and results always wrap.

## Test plan
WIDTH=16, STAGES=4.
- Add 0x7FFF + 0x0001, `sat` = 0 -> `s` = 0x8000, `ovf` = 1, `cout` = 0, `neg` = 1, `zero` = 0, with `out_valid` four edges after accept.
- Subtract 0x0005 − 0x0007 -> `s` = 0xFFFE, `cout` = 0, `neg` = 1, `ovf` = 0. Subtract 0x1234 − 0x1234 -> `s` = 0x0000, `zero` = 1, `cout` = 1.
- Stream 8 back-to-back random beats with `out_ready` low for 3 cycles mid-stream -> `in_ready` drops in the same cycles, all 8 results match a reference model, order is preserved, and outputs stay stable while stalled.
- Stream with `in_valid` toggling every cycle (bubbles) and `out_ready` = 1 -> results emerge with identical spacing and correct values.
- Assert `rst_n` low for 1 cycle with 3 beats in flight -> `out_valid` = 0 immediately and no result appears within 10 cycles after release.
- With `ADDSUB_SATURATE_EN` and `sat` = 1:
  - 0x7FFF + 0x0001 -> `s` = 0x7FFF, `ovf` = 1.
  - 0x8000 − 0x0001 -> `s` = 0x8000, `ovf` = 1, `neg` = 1.
  - With `sat` = 0, both cases wrap.
